// File: rtl/int_service_scheduler.sv
// Round-robin interrupt service scheduler: on a pending irq, reads the source's
// counter over APB, acknowledges it, then waits for the request level to drop.
module int_service_scheduler #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 16,
  parameter int          DROP_WAIT = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        enable,
  input  logic        linux_irq,
  input  logic        lim_irq,
  input  logic        itim_irq,
  output logic        linux_ack,
  output logic        lim_ack,
  output logic        itim_ack,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [15:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        svc_valid,
  output logic [1:0]  svc_src,
  output logic [31:0] svc_data,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DROP_WAIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DROP_LAST = DW'(DROP_WAIT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ACK, DROP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic [1:0]     ptr_q, ptr_d;
  logic           ok_q, ok_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [DW-1:0]  drop_q, drop_d;
  logic [7:0]     err_q, err_d;
  logic [31:0]    data_q, data_d;
  logic [1:0]     src_q, src_d;
  logic [15:0]    paddr_q, paddr_d;

  logic [2:0]     irq_vec;
  logic           found;
  logic [1:0]     pick, cand;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign irq_vec = {itim_irq, lim_irq, linux_irq};

  // Search starts at the pointer and wraps linux->lim->itim.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (!found && irq_vec[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    ok_d    = ok_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    err_d   = err_q;
    data_d  = data_q;
    src_d   = src_q;
    paddr_d = paddr_q;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          grant_d = pick;
          paddr_d = BASE_ADDR + {12'd0, 2'(pick + 2'd1), 2'b00};
          state_d = SETUP;
        end
      end
      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY && !PSLVERR) begin
          ok_d    = 1'b1;
          data_d  = PRDATA;
          src_d   = grant_q;
          state_d = ACK;
        end else if (PREADY || tmo_q == TMO_LAST) begin
          ok_d    = 1'b0;
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          state_d = ACK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ACK: begin
        drop_d  = '0;
        state_d = DROP;
      end
      DROP: begin
        if (!irq_vec[grant_q] || drop_q == DROP_LAST) begin
          ptr_d   = rr_next(grant_q);
          state_d = IDLE;
        end else begin
          drop_d = drop_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      ok_q    <= 1'b0;
      tmo_q   <= '0;
      drop_q  <= '0;
      err_q   <= 8'd0;
      data_q  <= 32'd0;
      src_q   <= 2'd0;
      paddr_q <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      ok_q    <= ok_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      data_q  <= data_d;
      src_q   <= src_d;
      paddr_q <= paddr_d;
    end
  end

  // Bus and ack outputs decode straight from state so reset clears them at once.
  always_comb begin
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    PADDR     = PSEL ? paddr_q : 16'd0;
    PWRITE    = 1'b0;
    PWDATA    = 32'd0;
    linux_ack = (state_q == ACK) && (grant_q == 2'd0);
    lim_ack   = (state_q == ACK) && (grant_q == 2'd1);
    itim_ack  = (state_q == ACK) && (grant_q == 2'd2);
    svc_valid = (state_q == ACK) && ok_q;
    svc_src   = src_q;
    svc_data  = data_q;
    err_count = err_q;
  end

endmodule

// File: tb/tb_int_service_scheduler.sv
// Scoreboard bench for int_service_scheduler: expected services are queued as
// stimulus is applied and retired when an ack appears.
module tb_int_service_scheduler;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        enable;
  logic        linux_irq, lim_irq, itim_irq;
  logic        linux_ack, lim_ack, itim_ack;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        svc_valid;
  logic [1:0]  svc_src;
  logic [31:0] svc_data;
  logic [7:0]  err_count;

  logic [31:0] rdata_v;
  logic        addr_mode;

  typedef struct {
    logic [1:0]  src;
    logic        ok;
    logic [31:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic        sb_en;
  logic [15:0] last_addr;
  int          n_chk = 0;
  int          n_err = 0;

  int_service_scheduler #(.BASE_ADDR(16'h0000), .TIMEOUT(16), .DROP_WAIT(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable),
    .linux_irq(linux_irq), .lim_irq(lim_irq), .itim_irq(itim_irq),
    .linux_ack(linux_ack), .lim_ack(lim_ack), .itim_ack(itim_ack),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .svc_valid(svc_valid), .svc_src(svc_src), .svc_data(svc_data),
    .err_count(err_count)
  );

  always #5 PCLK = ~PCLK;

  // Slave read data: either a fixed word or a word tagged with the address.
  assign PRDATA = addr_mode ? {16'hD00D, PADDR} : rdata_v;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic [1:0] src, input logic ok, input logic [31:0] data,
                      input logic [15:0] addr);
    exp_t e;
    e.src = src; e.ok = ok; e.data = data; e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic wait_ack(output logic [2:0] a);
    int n;
    a = 3'b000;
    n = 0;
    while (a == 3'b000 && n < 200) begin
      tick();
      a = {itim_ack, lim_ack, linux_ack};
      n++;
    end
    chk("ack_seen", {31'd0, (a != 3'b000)}, 32'd1);
  endtask

  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) last_addr <= PADDR;
    if (sb_en && (linux_ack || lim_ack || itim_ack)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", {29'd0, itim_ack, lim_ack, linux_ack}, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("sb_ack", {29'd0, itim_ack, lim_ack, linux_ack}, 32'(3'b001 << e_mon.src));
        chk("sb_valid", {31'd0, svc_valid}, {31'd0, e_mon.ok});
        if (e_mon.ok) begin
          chk("sb_src", {30'd0, svc_src}, {30'd0, e_mon.src});
          chk("sb_data", svc_data, e_mon.data);
        end
        chk("sb_addr", {16'd0, last_addr}, {16'd0, e_mon.addr});
      end
    end
  end

  initial begin
    logic [2:0] a;
    int         n;
    PRESET = 1'b1; enable = 1'b1;
    linux_irq = 1'b0; lim_irq = 1'b0; itim_irq = 1'b0;
    PREADY = 1'b1; PSLVERR = 1'b0; rdata_v = 32'd0; addr_mode = 1'b0;
    sb_en = 1'b1; last_addr = 16'd0;
    tick(); tick();
    chk("rst_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_acks", {29'd0, itim_ack, lim_ack, linux_ack}, 32'd0);
    chk("rst_valid", {31'd0, svc_valid}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_data", svc_data, 32'd0);
    chk("rst_paddr", {16'd0, PADDR}, 32'd0);
    PRESET = 1'b0;
    tick();

    // Single linux service, latency N+1/N+2/N+3
    rdata_v = 32'h0000_0005;
    linux_irq = 1'b1;
    push(2'd0, 1'b1, 32'h5, 16'h0004);
    tick();
    chk("lat_psel", {30'd0, PSEL, PENABLE}, 32'b10);
    chk("lat_paddr", {16'd0, PADDR}, 32'h0004);
    tick();
    chk("lat_penable", {30'd0, PSEL, PENABLE}, 32'b11);
    tick();
    chk("lat_ack", {30'd0, linux_ack, svc_valid}, 32'b11);
    chk("lat_src", {30'd0, svc_src}, 32'd0);
    chk("lat_data", svc_data, 32'h5);
    linux_irq = 1'b0;
    tick(); tick();

    // All three held from reset release: round-robin order
    PRESET = 1'b1;
    linux_irq = 1'b1; lim_irq = 1'b1; itim_irq = 1'b1;
    addr_mode = 1'b1;
    tick();
    PRESET = 1'b0;
    push(2'd0, 1'b1, 32'hD00D_0004, 16'h0004);
    push(2'd1, 1'b1, 32'hD00D_0008, 16'h0008);
    push(2'd2, 1'b1, 32'hD00D_000C, 16'h000C);
    wait_ack(a); chk("rr_first", {29'd0, a}, 32'b001);
    tick(); linux_irq = 1'b0;
    wait_ack(a); chk("rr_second", {29'd0, a}, 32'b010);
    tick(); lim_irq = 1'b0;
    wait_ack(a); chk("rr_third", {29'd0, a}, 32'b100);
    tick(); itim_irq = 1'b0;
    addr_mode = 1'b0;
    tick(); tick();

    // PREADY stuck low on lim: timeout after 16 ACCESS cycles
    PREADY = 1'b0;
    lim_irq = 1'b1;
    push(2'd1, 1'b0, 32'd0, 16'h0008);
    n = 0;
    while (!PENABLE && n < 10) begin tick(); n++; end
    n = 0;
    while (PENABLE && n < 40) begin tick(); n++; end
    chk("tmo_cycles", n, 16);
    chk("tmo_ack", {30'd0, lim_ack, svc_valid}, 32'b10);
    chk("tmo_err", {24'd0, err_count}, 32'd1);
    chk("tmo_data_kept", svc_data, 32'hD00D_000C);
    lim_irq = 1'b0;
    PREADY = 1'b1;
    tick(); tick();

    // PSLVERR on itim
    PSLVERR = 1'b1;
    itim_irq = 1'b1;
    push(2'd2, 1'b0, 32'd0, 16'h000C);
    wait_ack(a);
    chk("slverr_ack", {29'd0, a}, 32'b100);
    chk("slverr_valid", {31'd0, svc_valid}, 32'd0);
    chk("slverr_err", {24'd0, err_count}, 32'd2);
    itim_irq = 1'b0;
    PSLVERR = 1'b0;
    tick(); tick();

    // irq falls right after grant: service still completes
    rdata_v = 32'hCAFE_F00D;
    linux_irq = 1'b1;
    push(2'd0, 1'b1, 32'hCAFE_F00D, 16'h0004);
    tick();
    linux_irq = 1'b0;
    wait_ack(a);
    chk("fall_ack", {29'd0, a}, 32'b001);
    repeat (5) tick();
    chk("hold_data", svc_data, 32'hCAFE_F00D);
    chk("hold_src", {30'd0, svc_src}, 32'd0);

    // enable drops mid-service: completes, then no new grants
    rdata_v = 32'h1111_2222;
    lim_irq = 1'b1;
    push(2'd1, 1'b1, 32'h1111_2222, 16'h0008);
    tick();
    enable = 1'b0;
    wait_ack(a);
    chk("en_ack", {29'd0, a}, 32'b010);
    n = 0;
    repeat (30) begin tick(); if (PSEL) n++; end
    chk("en_gate_psel", n, 0);
    chk("en_hold_data", svc_data, 32'h1111_2222);
    chk("en_hold_src", {30'd0, svc_src}, 32'd1);
    lim_irq = 1'b0;
    enable = 1'b1;
    tick();

    // Reset during ACCESS
    PREADY = 1'b0;
    itim_irq = 1'b1;
    n = 0;
    while (!PENABLE && n < 10) begin tick(); n++; end
    tick(); tick();
    PRESET = 1'b1;
    tick();
    chk("mid_rst_bus", {30'd0, PSEL, PENABLE}, 32'd0);
    chk("mid_rst_acks", {29'd0, itim_ack, lim_ack, linux_ack}, 32'd0);
    chk("mid_rst_err", {24'd0, err_count}, 32'd0);
    chk("mid_rst_data", svc_data, 32'd0);
    itim_irq = 1'b0;
    PREADY = 1'b1;
    PRESET = 1'b0;
    tick();
    chk("mid_rst_idle", {31'd0, PSEL}, 32'd0);

    // 300 forced errors saturate the counter
    sb_en = 1'b0;
    PSLVERR = 1'b1;
    linux_irq = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_ack(a);
      if (i == 9) chk("sat_err_10", {24'd0, err_count}, 32'd10);
    end
    linux_irq = 1'b0;
    PSLVERR = 1'b0;
    repeat (3) tick();
    chk("sat_err_255", {24'd0, err_count}, 32'd255);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/int_service_scheduler.md
INT_SERVICE_SCHEDULER -- requirements
Module: int_service_scheduler

Interface
REQ-001 Parameters:
- BASE_ADDR, 16'h0000, APB base of the interrupt counter block.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY.
- DROP_WAIT, 8, maximum cycles waiting for the serviced irq to fall.
REQ-002 PCLK  in  1  sole clock; all logic on rising edge.
REQ-003 PRESET  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  allow new services; low blocks new grants only.
REQ-005 linux_irq, lim_irq, itim_irq  in  1 each  level interrupt requests from counter block.
REQ-006 linux_ack, lim_ack, itim_ack  out  1 each  one-cycle acknowledge pulses.
REQ-007 PSEL, PENABLE, PWRITE  out  1 each  APB master control; PWRITE is always 0.
REQ-008 PADDR  out  16  APB address; PWDATA  out  32  constant 0.
REQ-009 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB slave response.
REQ-010 svc_valid  out  1  one-cycle pulse, service read completed OK.
REQ-011 svc_src  out  2  serviced source (0 linux, 1 lim, 2 itim); svc_data  out  32  captured PRDATA.
REQ-012 err_count  out  8  saturating count of PSLVERR and timeout events.

Function
REQ-013 FSM states: IDLE, SETUP, ACCESS, ACK, DROP.
REQ-014 IDLE: if enable=1 and any irq is high, grant by round-robin starting at the priority pointer, latch the grant, and go to SETUP next cycle.
REQ-015 Round-robin order is linux->lim->itim->linux. After DROP, the pointer moves to the source after the granted one.
REQ-016 SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR=BASE_ADDR+4 (linux), +8 (lim) or +12 (itim); then go to ACCESS.
REQ-017 ACCESS: PSEL=1, PENABLE=1, PADDR held; stay until PREADY=1 or TIMEOUT cycles have elapsed.
REQ-018 PREADY=1 and PSLVERR=0: capture PRDATA into svc_data and go to ACK.
REQ-019 PREADY=1 and PSLVERR=1, or timeout: err_count+1 (saturates at 255), svc_data unchanged, go to ACK.
REQ-020 ACK (1 cycle):
- PSEL=0, PENABLE=0.
- Granted *_ack=1; other acks 0.
- svc_valid=1 and svc_src=grant only if the read succeeded.
- Go to DROP.
REQ-021 DROP: wait until the granted irq is low or DROP_WAIT cycles elapse, then go to IDLE; no re-ack.
REQ-022 Latency: irq high in IDLE at cycle N; PSEL at N+1; PENABLE at N+2; with PREADY=1 at N+2, ack and svc_valid at N+3.
REQ-023 PSEL/PENABLE are never 1 outside SETUP/ACCESS; at most one *_ack is high in any cycle.
REQ-024 enable falling mid-service: the current service completes through DROP; the FSM then stays in IDLE.
REQ-025 irq falling after grant: the service still completes (read and ack issued).
REQ-026 svc_src and svc_data hold their last values between services.

Reset
REQ-027 PRESET=1 at a clock edge puts the FSM in IDLE and sets the pointer to linux. All outputs go to 0, including svc_data and err_count. This applies at any time, including mid-APB transfer.

Verification
REQ-028 Single linux_irq, PREADY=1, PRDATA=0x0000_0005:
- PADDR=0x0004 at N+1.
- linux_ack=1 and svc_valid=1 at N+3, svc_src=0, svc_data=0x5.
REQ-029 All three irqs held high from reset release, each dropping 1 cycle after its ack:
- Reads at 0x0004, 0x0008, 0x000C in that order.
- Three acks in the order linux, lim, itim.
REQ-030 PREADY held 0 during a lim service:
- Timeout after 16 ACCESS cycles.
- err_count=1, lim_ack pulses, no svc_valid.
REQ-031 PSLVERR=1 with PREADY on an itim read: err_count increments, itim_ack=1, svc_valid=0.
REQ-032 PRESET asserted during ACCESS: next cycle PSEL=0, PENABLE=0, all acks 0, err_count=0, FSM in IDLE.
REQ-033 Error saturation and enable gating:
- 300 forced errors -> err_count=255.
- enable=0 with irq pending -> PSEL stays 0.
